instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  hold request from decode; freezes the fetch stream.
REQ-005 redirect_valid  input  1  branch/jump taken this cycle.
REQ-006 redirect_target  input  32  byte address of the redirect destination.
REQ-007 imem_addr  output  32  byte address to the instruction memory; combinational from internal state and inputs.
REQ-008 imem_rdata  input  32  little-endian instruction word; valid the cycle after imem_addr is presented (registered read).
REQ-009 if_valid  output  1  if_instr/if_pc hold a live instruction for the IF/ID register.
REQ-010 if_instr  output  32  fetched instruction; equals imem_rdata.
REQ-011 if_pc  output  32  byte address of if_instr.
REQ-012 fault  output  1  sticky misaligned-redirect flag.

Function
REQ-013 Internal state SHALL be: pc (next address to issue), req_pc (address issued last cycle), req_valid, and a 2-state FSM RUN/FAULT.
REQ-014 Address select priority SHALL be: FAULT -> req_pc; redirect_valid -> redirect_target; stall -> req_pc; else -> pc.
REQ-015 RUN, no redirect, no stall: next cycle req_pc <= pc, req_valid <= 1, pc <= pc + 4.
REQ-016 RUN, stall=1, no redirect: pc, req_pc, req_valid SHALL hold; imem_addr = req_pc re-reads the held word, so if_instr/if_pc/if_valid are stable on the following cycle.
REQ-017 RUN, redirect_valid=1 with redirect_target[1:0]==2'b00: if_valid SHALL be 0 this cycle (squash in-flight word); next cycle req_pc <= redirect_target, req_valid <= 1, pc <= redirect_target + 4; stall is ignored.
REQ-018 Redirect-to-valid latency SHALL be one cycle: target instruction appears with if_valid=1 on the cycle after redirect_valid.
REQ-019 RUN, redirect_valid=1 with redirect_target[1:0]!=0: if_valid=0 this cycle; next cycle FSM -> FAULT, fault <= 1, req_valid <= 0, pc and req_pc hold.
REQ-020 FAULT: if_valid=0, fault=1, all state held; stall and redirect_valid ignored; exit only via reset.
REQ-021 if_valid SHALL equal req_valid AND NOT redirect_valid AND FSM==RUN.
REQ-022 pc + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) without fault.
REQ-023 if_pc SHALL equal req_pc; if_instr SHALL equal imem_rdata without modification.

Reset
REQ-024 While reset=1 at posedge: pc <= RESET_PC, req_pc <= RESET_PC, req_valid <= 0, FSM <= RUN, fault <= 0; overrides stall and redirect.
REQ-025 In the cycle after reset deasserts, imem_addr = RESET_PC and if_valid = 0; one cycle later if_valid = 1, if_pc = RESET_PC.
REQ-026 Reset asserted mid-stream or in FAULT SHALL discard any in-flight word and restart from RESET_PC.

Verification
REQ-027 Reset, then 6 free-running cycles with program memory -> if_pc sequence 0,4,8,12,16 with matching words (e.g. word at 0 = 32'h0140_0193), if_valid=1 from cycle 2.
REQ-028 Stall held 3 cycles while if_pc=8 -> if_pc=8, if_instr unchanged, if_valid=1 for all 3 cycles; next cycle if_pc=12.
REQ-029 redirect_valid=1, target=28 while if_pc=16 -> if_valid=0 that cycle; next cycle if_pc=28, then 32.
REQ-030 redirect_valid=1 and stall=1 same cycle, target=36 -> redirect wins; next cycle if_pc=36.
REQ-031 redirect_target=32'h0000_0022 -> if_valid=0; next cycle fault=1, if_valid=0, stall/redirect ignored until reset, then if_pc=RESET_PC two cycles after reset release.
REQ-032 Redirect to 32'hFFFF_FFFC -> if_pc=FFFF_FFFC then 0000_0000, fault stays 0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Purpose: program-counter sequencing and instruction fetch from a registered-read instruction memory.
// Latency: one cycle from imem_addr to if_instr/if_pc; redirect target is live the cycle after redirect_valid.
// Backpressure: stall holds pc/req_pc and re-reads the held word; a misaligned redirect locks the unit until reset.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fault
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        req_valid_q, req_valid_d;
    logic        fault_q, fault_d;

    logic        redirect_misaligned;

    assign redirect_misaligned = (redirect_target[1:0] != 2'b00);

    // Address select: a locked unit and a stalled unit both re-present the held address.
    always_comb begin
        imem_addr = pc_q;
        if (state_q == ST_FAULT) begin
            imem_addr = req_pc_q;
        end else if (redirect_valid) begin
            imem_addr = redirect_target;
        end else if (stall) begin
            imem_addr = req_pc_q;
        end
    end

    // Next-state logic for the fetch stream and the RUN/FAULT machine.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        req_valid_d = req_valid_q;
        fault_d     = fault_q;
        if (state_q == ST_RUN) begin
            if (redirect_valid) begin
                if (redirect_misaligned) begin
                    // Lock up: keep addresses, drop the live word.
                    state_d     = ST_FAULT;
                    fault_d     = 1'b1;
                    req_valid_d = 1'b0;
                end else begin
                    req_pc_d    = redirect_target;
                    req_valid_d = 1'b1;
                    pc_d        = redirect_target + 32'd4;
                end
            end else if (!stall) begin
                // pc + 4 wraps naturally at 2^32.
                req_pc_d    = pc_q;
                req_valid_d = 1'b1;
                pc_d        = pc_q + 32'd4;
            end
        end
    end

    // State registers with synchronous reset that discards any in-flight word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            req_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
            fault_q     <= fault_d;
        end
    end

    // The word returning this cycle is squashed when a redirect is taken or the unit is locked.
    assign if_valid = req_valid_q && !redirect_valid && (state_q == ST_RUN);
    assign if_instr = imem_rdata;
    assign if_pc    = req_pc_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .fault           (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory contents: fixed word at 0, scrambled address elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0140_0193;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Registered-read instruction memory.
    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then apply new inputs away from the edge; checks follow after settle.
    task automatic cyc(input logic rst, input logic stl, input logic rv, input logic [31:0] tgt);
        @(posedge clk);
        #2;
        reset = rst; stall = stl; redirect_valid = rv; redirect_target = tgt;
        #1;
    endtask

    task automatic chk_live(input string tag, input logic [31:0] pc);
        chk({tag, "_vld"},   {31'd0, if_valid}, 32'd1);
        chk({tag, "_pc"},    if_pc, pc);
        chk({tag, "_instr"}, if_instr, mem_word(pc));
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
        // Reset with stall/redirect asserted must still reset.
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        chk("rst_vld",   {31'd0, if_valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_addr",  imem_addr, 32'h0000_0000);

        // First cycle after release: issue RESET_PC, nothing live yet.
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk("rel_vld",  {31'd0, if_valid}, 32'd0);
        chk("rel_addr", imem_addr, 32'h0000_0000);

        // Free-running sequence 0,4,8.
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_live("run0", 32'd0);
        chk("run0_word", if_instr, 32'h0140_0193);
        chk("run0_addr", imem_addr, 32'd4);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_live("run4", 32'd4);

        // Stall asserted for 3 cycles starting when if_pc=8.
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        chk_live("stl0", 32'd8);
        chk("stl0_addr", imem_addr, 32'd8);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        chk_live("stl1", 32'd8);
        cyc(1'b0, 1'b1, 1'b0, 32'd0);
        chk_live("stl2", 32'd8);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_live("stl_rel", 32'd8);
        chk("stl_rel_addr", imem_addr, 32'd12);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_live("run12", 32'd12);

        // Redirect to 28 while if_pc=16: word squashed.
        cyc(1'b0, 1'b0, 1'b1, 32'd28);
        chk("rd_pc",   if_pc, 32'd16);
        chk("rd_vld",  {31'd0, if_valid}, 32'd0);
        chk("rd_addr", imem_addr, 32'd28);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_live("rd28", 32'd28);

        // Redirect and stall together while if_pc=32: redirect wins.
        cyc(1'b0, 1'b1, 1'b1, 32'd36);
        chk("rs_pc",   if_pc, 32'd32);
        chk("rs_vld",  {31'd0, if_valid}, 32'd0);
        chk("rs_addr", imem_addr, 32'd36);
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("rs36_pc", if_pc, 32'd36);
        chk("rw_vld",  {31'd0, if_valid}, 32'd0);

        // Wrap at top of address space.
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_live("wrap_top", 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0022);
        chk("wrap0_pc",    if_pc, 32'h0000_0000);
        chk("wrap0_fault", {31'd0, fault}, 32'd0);
        chk("mis_vld",     {31'd0, if_valid}, 32'd0);

        // Locked in FAULT: stall and redirect ignored.
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk("flt_fault", {31'd0, fault}, 32'd1);
        chk("flt_vld",   {31'd0, if_valid}, 32'd0);
        chk("flt_addr",  imem_addr, 32'h0000_0000);
        cyc(1'b0, 1'b1, 1'b1, 32'd40);
        chk("flt2_fault", {31'd0, fault}, 32'd1);
        chk("flt2_vld",   {31'd0, if_valid}, 32'd0);
        chk("flt2_addr",  imem_addr, 32'h0000_0000);
        cyc(1'b0, 1'b0, 1'b1, 32'd44);
        chk("flt3_pc",    if_pc, 32'h0000_0000);
        chk("flt3_fault", {31'd0, fault}, 32'd1);

        // Reset from FAULT restarts cleanly.
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk("rr_fault", {31'd0, fault}, 32'd0);
        chk("rr_vld",   {31'd0, if_valid}, 32'd0);
        chk("rr_addr",  imem_addr, 32'h0000_0000);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_live("rr0", 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_live("rr4", 32'd4);

        // Mid-stream reset discards the live word.
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk("ms_vld", {31'd0, if_valid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        chk_live("ms0", 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
